pulse_period_meter: RTL and testbench
=====================================

Name: pulse_period_meter

Overview:
- Receive side of the periodic-tick scheme: measures the clock-cycle interval between rising edges of an incoming tick (e.g. a divider's one-cycle match strobe).
- Reports each measured period, checks it against an expected value with tolerance, declares lock after consecutive good periods, and flags loss of tick.
- Sits downstream of tick generators as a self-check or monitor.

Parameters:
- WIDTH, 32, width of period counter and outputs.
- EXPECTED_PERIOD, 2_000_000, nominal interval in clk cycles.
- TOLERANCE, 0, allowed absolute deviation from EXPECTED_PERIOD, in cycles.
- LOCK_COUNT, 4, consecutive in-tolerance periods required to assert locked (>=1).
- TIMEOUT_CYCLES, 4_000_000, cycles without an edge before timeout. Must be > EXPECTED_PERIOD+TOLERANCE and < 2^WIDTH-1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  measurement enable; low forces IDLE.
- pulse_in  in  1  tick input, synchronous to clk, any high width.
- period  out  WIDTH  last measured interval, held until next measurement.
- period_valid  out  1  one-cycle strobe, period updated.
- in_tol  out  1  last measured period within tolerance; held.
- locked  out  1  LOCK_COUNT consecutive in-tolerance periods seen.
- timeout  out  1  one-cycle strobe on tick loss.

Behaviour:
- Single clock, one synchronous active-high reset (rst); no other resets.
- Reset: state=IDLE, cnt=0, pulse_d=0, period=0, period_valid=0, in_tol=0, locked=0, timeout=0, consec=0.
- Edge detect: rise = pulse_in & ~pulse_d. pulse_d <= pulse_in every cycle, including in IDLE and while enable=0. A pulse held high gives exactly one rise.
- States: IDLE (waiting for first edge) and MEASURE.
- IDLE:
  - rise && enable -> MEASURE, cnt<=1, no period_valid.
  - Otherwise stay; cnt holds 0.
- MEASURE, rise:
  - period<=cnt, period_valid<=1 on the next cycle (1-cycle latency), cnt<=1.
  - Interval definition: rises at cycles t and t+N give period=N.
  - in_tol<=(|cnt-EXPECTED_PERIOD| <= TOLERANCE). Compare without wrap: use an unsigned difference of the larger minus the smaller.
  - In tolerance: consec<=min(consec+1, LOCK_COUNT); locked<=1 when the updated consec==LOCK_COUNT.
  - Out of tolerance: consec<=0, locked<=0.
- MEASURE, no rise:
  - cnt<=cnt+1.
  - If cnt==TIMEOUT_CYCLES: timeout<=1 for one cycle, locked<=0, consec<=0, in_tol<=0, cnt<=0, state->IDLE. period is retained.
- Simultaneous rise and cnt==TIMEOUT_CYCLES: treated as a measurement (period=TIMEOUT_CYCLES, out of tolerance), no timeout.
- period_valid and timeout are never high in the same cycle.
- enable=0:
  - Next cycle state=IDLE, cnt=0, consec=0, locked=0, in_tol=0.
  - period is held; no strobes.
  - On re-enable, the first rise only arms (no measurement).
- Reset mid-measurement: all state returns to reset values on the next edge; an in-flight interval is discarded.

Test Plan (sim params: WIDTH=8, EXPECTED_PERIOD=10, TOLERANCE=1, LOCK_COUNT=3, TIMEOUT_CYCLES=25):
1. Single-cycle ticks every 10 cycles, 5 ticks -> no strobe on tick 1. period=10 with period_valid one cycle after ticks 2..5. in_tol=1. locked rises one cycle after tick 4.
2. Intervals 10,10,10 then 13 then 9 -> locked=1 after the third good period. At the 13: in_tol=0, locked=0. At the 9: in_tol=1, locked=0 (consec=1).
3. Lock at 10, then pulse_in stays low -> timeout strobe exactly 25 cycles after the last rise (when cnt==25). locked=0, state IDLE, period still 10. The next tick produces no period_valid.
4. pulse_in held high 4 cycles, rising every 10 cycles -> period=10 (one rise per pulse), no spurious measurements.
5. Rise exactly at cnt==25 -> period=25, period_valid=1, in_tol=0, no timeout.
6. Locked and mid-interval: assert rst one cycle -> all outputs 0 next cycle. Separately, drop enable for 3 cycles -> locked=0, period held, first tick after re-enable only arms.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures the clk-cycle interval between rising edges of pulse_in, checks it
// against EXPECTED_PERIOD +/- TOLERANCE, tracks lock and flags tick loss.
module pulse_period_meter #(
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned EXPECTED_PERIOD = 2_000_000,
  parameter int unsigned TOLERANCE       = 0,
  parameter int unsigned LOCK_COUNT      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 4_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             pulse_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             in_tol,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned CW = $clog2(LOCK_COUNT + 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam logic [WIDTH-1:0] EXP_W  = WIDTH'(EXPECTED_PERIOD);
  localparam logic [WIDTH-1:0] TOL_W  = WIDTH'(TOLERANCE);
  localparam logic [WIDTH-1:0] TO_W   = WIDTH'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]    LOCK_W = CW'(LOCK_COUNT);

  logic [0:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] period_nxt;
  logic [CW-1:0]    consec, consec_nxt;
  logic             pulse_d;
  logic             period_valid_nxt, in_tol_nxt, locked_nxt, timeout_nxt;
  logic             rise;
  logic [WIDTH-1:0] dev;
  logic [CW-1:0]    consec_inc;

  // Next-state and next-output logic
  always_comb begin
    rise       = pulse_in & ~pulse_d;
    dev        = (cnt >= EXP_W) ? (cnt - EXP_W) : (EXP_W - cnt);
    consec_inc = (consec >= LOCK_W) ? LOCK_W : (consec + CW'(1));

    state_nxt        = state;
    cnt_nxt          = cnt;
    period_nxt       = period;
    consec_nxt       = consec;
    period_valid_nxt = 1'b0;
    in_tol_nxt       = in_tol;
    locked_nxt       = locked;
    timeout_nxt      = 1'b0;

    if (!enable) begin
      state_nxt  = IDLE;
      cnt_nxt    = '0;
      consec_nxt = '0;
      locked_nxt = 1'b0;
      in_tol_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            state_nxt = MEASURE;
            cnt_nxt   = WIDTH'(1);
          end else begin
            cnt_nxt = '0;
          end
        end
        MEASURE: begin
          if (rise) begin
            // A rise wins over a coincident timeout
            period_nxt       = cnt;
            period_valid_nxt = 1'b1;
            cnt_nxt          = WIDTH'(1);
            if (dev <= TOL_W) begin
              in_tol_nxt = 1'b1;
              consec_nxt = consec_inc;
              locked_nxt = (consec_inc == LOCK_W);
            end else begin
              in_tol_nxt = 1'b0;
              consec_nxt = '0;
              locked_nxt = 1'b0;
            end
          end else if (cnt == TO_W) begin
            timeout_nxt = 1'b1;
            locked_nxt  = 1'b0;
            consec_nxt  = '0;
            in_tol_nxt  = 1'b0;
            cnt_nxt     = '0;
            state_nxt   = IDLE;
          end else begin
            cnt_nxt = cnt + WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      pulse_d      <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
      in_tol       <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
      consec       <= '0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      pulse_d      <= pulse_in;
      period       <= period_nxt;
      period_valid <= period_valid_nxt;
      in_tol       <= in_tol_nxt;
      locked       <= locked_nxt;
      timeout      <= timeout_nxt;
      consec       <= consec_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_period_meter.sv
// Scoreboard bench for pulse_period_meter: an interval-based reference model
// predicts each strobe, a monitor pops and compares when the DUT strobes.
module tb_pulse_period_meter;

  localparam int unsigned W   = 8;
  localparam int unsigned EXP = 10;
  localparam int unsigned TOL = 1;
  localparam int unsigned LC  = 3;
  localparam int unsigned TO  = 25;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         pulse_in = 1'b0;
  logic [W-1:0] period;
  logic         period_valid, in_tol, locked, timeout;

  pulse_period_meter #(
    .WIDTH(W), .EXPECTED_PERIOD(EXP), .TOLERANCE(TOL),
    .LOCK_COUNT(LC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .pulse_in(pulse_in),
    .period(period), .period_valid(period_valid), .in_tol(in_tol),
    .locked(locked), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int unsigned edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    bit          is_to;
    int unsigned edge_n;
    int unsigned per;
    bit          tol;
    bit          lk;
  } ev_t;

  ev_t q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Reference model: remembers when the last accepted rise happened and
  // derives each interval as a difference of edge numbers.
  bit          m_prev = 1'b0;
  bit          m_armed = 1'b0;
  int unsigned m_last = 0;
  int unsigned m_good = 0;
  int unsigned m_period = 0;

  task automatic model(input int unsigned e, input bit p, input bit en, input bit r);
    bit          rise_m;
    int unsigned el, d;
    ev_t         ev;
    if (r) begin
      m_prev = 1'b0; m_armed = 1'b0; m_good = 0; m_period = 0;
      return;
    end
    rise_m = p && !m_prev;
    m_prev = p;
    if (!en) begin
      m_armed = 1'b0; m_good = 0;
      return;
    end
    if (!m_armed) begin
      if (rise_m) begin
        m_armed = 1'b1; m_last = e;
      end
      return;
    end
    el = e - m_last;
    if (rise_m) begin
      d = (el >= EXP) ? el - EXP : EXP - el;
      if (d <= TOL) m_good = (m_good + 1 > LC) ? LC : m_good + 1;
      else m_good = 0;
      m_period = el;
      m_last = e;
      ev = '{is_to: 1'b0, edge_n: e, per: el, tol: (d <= TOL), lk: (m_good == LC)};
      q.push_back(ev);
    end else if (el == TO) begin
      m_armed = 1'b0; m_good = 0;
      ev = '{is_to: 1'b1, edge_n: e, per: m_period, tol: 1'b0, lk: 1'b0};
      q.push_back(ev);
    end
  endtask

  task automatic drive(input bit p, input bit en, input bit r);
    @(negedge clk);
    pulse_in = p; enable = en; rst = r;
    model(edge_cnt + 1, p, en, r);
  endtask

  task automatic tick(input int unsigned n, input int unsigned w);
    for (int i = 0; i < n; i++) drive(i < w, 1'b1, 1'b0);
  endtask

  task automatic lock_up();
    for (int i = 0; i < 4; i++) tick(EXP, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_period"}, 32'(period), 0);
    chk({tag, "_period_valid"}, 32'(period_valid), 0);
    chk({tag, "_in_tol"}, 32'(in_tol), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_timeout"}, 32'(timeout), 0);
  endtask

  // Monitor: compare every strobe against the oldest prediction
  always @(negedge clk) begin
    ev_t ev;
    if (q.size() > 0 && q[0].edge_n < edge_cnt) begin
      ev = q.pop_front();
      chk("missed_strobe_edge", edge_cnt, ev.edge_n);
    end
    if (period_valid || timeout) begin
      chk("strobe_exclusive", 32'(period_valid & timeout), 0);
      if (q.size() == 0) begin
        chk("spurious_strobe", 32'({period_valid, timeout}), 0);
      end else begin
        ev = q.pop_front();
        chk("strobe_edge", edge_cnt, ev.edge_n);
        chk("timeout_kind", 32'(timeout), 32'(ev.is_to));
        chk("period", 32'(period), ev.per);
        chk("in_tol", 32'(in_tol), 32'(ev.tol));
        chk("locked", 32'(locked), 32'(ev.lk));
      end
    end
  end

  initial begin
    int unsigned n, w;
    drive(0, 0, 1);
    drive(0, 0, 1);
    drive(0, 1, 0);
    check_all_zero("reset");

    // Regular single-cycle ticks; first only arms
    repeat (5) tick(EXP, 1);

    // Lock, then an out-of-tolerance and a recovering interval
    drive(0, 1, 1);
    drive(0, 1, 0);
    tick(10, 1); tick(10, 1); tick(10, 1); tick(10, 1);
    tick(13, 1); tick(9, 1); tick(10, 1);

    // Tick loss after lock
    lock_up();
    repeat (30) drive(0, 1, 0);
    chk("after_timeout_locked", 32'(locked), 0);
    chk("after_timeout_period", 32'(period), 32'(m_period));
    tick(EXP, 1);

    // Wide pulses give one rise each
    repeat (5) tick(EXP, 4);

    // Rise exactly at the timeout count
    tick(TO, 1);
    tick(EXP, 1);

    // Reset mid-interval while locked
    lock_up();
    repeat (4) drive(0, 1, 0);
    drive(0, 1, 1);
    drive(0, 1, 0);
    check_all_zero("midreset");

    // Enable drop while locked
    lock_up();
    tick(4, 1);
    repeat (3) drive(0, 0, 0);
    drive(0, 1, 0);
    chk("disable_locked", 32'(locked), 0);
    chk("disable_in_tol", 32'(in_tol), 0);
    chk("disable_period_held", 32'(period), 32'(m_period));
    repeat (3) tick(EXP, 1);

    // Randomised intervals, mostly near nominal, with occasional disruptions
    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 9) < 7) n = $urandom_range(EXP - 2, EXP + 2);
      else n = $urandom_range(2, TO + 5);
      w = $urandom_range(1, n - 1);
      tick(n, w);
      if ($urandom_range(0, 29) == 0) repeat ($urandom_range(1, 3)) drive(0, 0, 0);
      if ($urandom_range(0, 59) == 0) drive(0, 1, 1);
    end

    repeat (5) drive(0, 1, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
